uart_baud_nco: RTL

Parametrised, fractional UART baud-tick generator; successor to the integer half-period clock divider. Two phase-accumulator NCOs produce single-cycle enable strobes: one at the bit rate for the transmitter, one at OVERSAMPLE× for the receiver. It adds clock-frequency independence, sub-cycle rate accuracy, glitch-free runtime rate switching, receiver phase resync, and an unsupported-rate flag. It sits between the register block (`baud` source) and the UART TX/RX engines, which run on `clk` and qualify on the ticks.

---
 rtl/uart_baud_nco_if.sv | 29 ++
 rtl/uart_baud_nco.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_baud_nco_if.sv
// Rate-select / strobe bundle between register block, UART engines and NCO.
// master: drives en, baud, sync; slave (NCO): drives ticks, phase, flags.
interface uart_baud_nco_if #(
  parameter int OVERSAMPLE = 16
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  logic            en;
  logic [16:0]     baud;
  logic            sync;
  logic            tx_tick;
  logic            rx_tick;
  logic            rx_mid;
  logic [PH_W-1:0] rx_phase;
  logic            baud_chg;
  logic            baud_err;

  modport master (
    output en, baud, sync,
    input  tx_tick, rx_tick, rx_mid,
    input  rx_phase, baud_chg, baud_err
  );

  modport slave (
    input  en, baud, sync,
    output tx_tick, rx_tick, rx_mid,
    output rx_phase, baud_chg, baud_err
  );
endinterface

// File: rtl/uart_baud_nco.sv
// Fractional UART baud-tick generator: TX and RX phase-accumulator NCOs.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   in  en, baud[16:0], sync
//   out tx_tick, rx_tick, rx_mid, rx_phase, baud_chg, baud_err
module uart_baud_nco #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input logic            clk,
  input logic            rst,
  uart_baud_nco_if.slave bus
);
  localparam int PH_W  = $clog2(OVERSAMPLE);
  localparam int NRATE = 8;
  localparam logic [2:0] SEL_9600 = 3'd1;

  typedef logic [NRATE-1:0][ACC_W-1:0] inc_tbl_t;

  function automatic longint unsigned rate_of(input int idx);
    case (idx)
      0:       return 64'd4800;
      1:       return 64'd9600;
      2:       return 64'd14400;
      3:       return 64'd19200;
      4:       return 64'd38400;
      5:       return 64'd57600;
      6:       return 64'd115200;
      7:       return 64'd128000;
      default: return 64'd9600;
    endcase
  endfunction

  // Rounded B*mult*2^ACC_W / CLK_FREQ in 64-bit math.
  function automatic logic [63:0] inc_of(
    input longint unsigned b,
    input longint unsigned mult
  );
    logic [63:0] num;
    num = (b * mult) << ACC_W;
    return (num + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  endfunction

  function automatic inc_tbl_t build_tbl(
    input longint unsigned mult
  );
    inc_tbl_t t;
    for (int i = 0; i < NRATE; i++)
      t[i] = ACC_W'(inc_of(rate_of(i), mult));
    return t;
  endfunction

  localparam inc_tbl_t INC_TX = build_tbl(64'd1);
  localparam inc_tbl_t INC_RX = build_tbl(64'(OVERSAMPLE));
  localparam logic [63:0] INC_RX_MAX =
    inc_of(64'd128000, 64'(OVERSAMPLE));

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of 2 in 4..64");
  end
  if (ACC_W < 16 || ACC_W > 40) begin : g_bad_accw
    $error("ACC_W must be in 16..40");
  end
  if (CLK_FREQ <= 128000 * OVERSAMPLE) begin : g_bad_clk
    $error("CLK_FREQ too low for OVERSAMPLE");
  end
  if (INC_RX_MAX >= (64'd1 << ACC_W)) begin : g_bad_inc
    $error("RX increment overflows accumulator");
  end

  logic [2:0]       dec_sel;
  logic             dec_err;
  logic [2:0]       sel_q, sel_d;
  logic [ACC_W-1:0] acc_tx_q, acc_tx_d;
  logic [ACC_W-1:0] acc_rx_q, acc_rx_d;
  logic [ACC_W:0]   sum_tx, sum_rx;
  logic [PH_W-1:0]  ph_q, ph_d, ph_inc;
  logic             tx_q, tx_d;
  logic             rx_q, rx_d;
  logic             mid_q, mid_d;
  logic             chg_q, chg_d;
  logic             err_q;

  always_comb begin
    dec_sel = SEL_9600;
    dec_err = 1'b0;
    unique case (1'b1)
      (bus.baud == 17'd4800):   dec_sel = 3'd0;
      (bus.baud == 17'd9600):   dec_sel = 3'd1;
      (bus.baud == 17'd14400):  dec_sel = 3'd2;
      (bus.baud == 17'd19200):  dec_sel = 3'd3;
      (bus.baud == 17'd38400):  dec_sel = 3'd4;
      (bus.baud == 17'd57600):  dec_sel = 3'd5;
      (bus.baud == 17'd115200): dec_sel = 3'd6;
      (bus.baud == 17'd128000): dec_sel = 3'd7;
      default:                  dec_err = 1'b1;
    endcase
  end

  always_comb begin
    sum_tx   = {1'b0, acc_tx_q} + {1'b0, INC_TX[sel_q]};
    sum_rx   = {1'b0, acc_rx_q} + {1'b0, INC_RX[sel_q]};
    ph_inc   = ph_q + 1'b1;
    sel_d    = sel_q;
    acc_tx_d = acc_tx_q;
    acc_rx_d = acc_rx_q;
    ph_d     = ph_q;
    tx_d     = 1'b0;
    rx_d     = 1'b0;
    mid_d    = 1'b0;
    chg_d    = 1'b0;
    if (dec_sel != sel_q) begin
      // New rate restarts both NCOs from zero phase.
      sel_d    = dec_sel;
      acc_tx_d = '0;
      acc_rx_d = '0;
      ph_d     = '0;
      chg_d    = 1'b1;
    end else if (bus.en) begin
      acc_tx_d = sum_tx[ACC_W-1:0];
      tx_d     = sum_tx[ACC_W];
      if (bus.sync) begin
        acc_rx_d = '0;
        ph_d     = '0;
      end else begin
        acc_rx_d = sum_rx[ACC_W-1:0];
        rx_d     = sum_rx[ACC_W];
        if (sum_rx[ACC_W]) begin
          ph_d  = ph_inc;
          mid_d = (ph_inc == PH_W'(OVERSAMPLE / 2));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= SEL_9600;
      acc_tx_q <= '0;
      acc_rx_q <= '0;
      ph_q     <= '0;
      tx_q     <= 1'b0;
      rx_q     <= 1'b0;
      mid_q    <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      acc_tx_q <= acc_tx_d;
      acc_rx_q <= acc_rx_d;
      ph_q     <= ph_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      mid_q    <= mid_d;
      chg_q    <= chg_d;
      err_q    <= dec_err;
    end
  end

  assign bus.tx_tick  = tx_q;
  assign bus.rx_tick  = rx_q;
  assign bus.rx_mid   = mid_q;
  assign bus.rx_phase = ph_q;
  assign bus.baud_chg = chg_q;
  assign bus.baud_err = err_q;
endmodule
